tick_serializer: RTL and testbench

- Consumes the periodic one-cycle terminal-count strobe from the team's period counter and uses it as a bit-rate tick to serialize parallel words onto a single line.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, then STOP_BITS stop bits (1).
- Upstream logic supplies words through a valid/ready handshake; the line idles high.

---
 rtl/tick_serializer_pkg.sv | 21 ++
 rtl/tick_serializer.sv | 106 ++++++++++
 tb/tb_tick_serializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_serializer_pkg.sv
// Shared state encoding for the tick-driven serializer.
// The numeric codes are fixed so other blocks and debug views can decode the state.
package tick_serializer_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_SYNC  = 3'd1;
  localparam logic [ST_W-1:0] ST_START = 3'd2;
  localparam logic [ST_W-1:0] ST_DATA  = 3'd3;
  localparam logic [ST_W-1:0] ST_STOP  = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_SYNC  = ST_SYNC,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } state_t;

endpackage

// File: rtl/tick_serializer.sv
// Serializes words as start bit, LSB-first data and stop bits, moving one bit per tick strobe.
// Every line transition is aligned to a tick, so each bit lasts exactly one tick period.
module tick_serializer
  import tick_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  state_t                  state;
  logic [DATA_WIDTH-1:0]   shift;
  logic [IDX_W-1:0]        bit_idx;
  logic [1:0]              stop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // Ticks are ignored here, so the start bit always waits for a fresh tick.
        S_IDLE: begin
          if (valid && ready) begin
            shift <= data;
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= S_SYNC;
          end
        end

        S_SYNC: begin
          if (tick) begin
            tx    <= 1'b0;
            state <= S_START;
          end
        end

        S_START: begin
          if (tick) begin
            tx      <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              tx       <= 1'b1;
              stop_cnt <= '0;
              state    <= S_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        // The last stop bit ends on a tick; ready returns together with the done pulse.
        S_STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              done  <= 1'b1;
              ready <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 2'd1;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_serializer.sv
// Bench for tick_serializer: one-stop and two-stop instances share clock, tick, data and reset,
// and are compared every cycle against a frame-level model of the serial line.
module tb_tick_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid1 = 1'b0, valid2 = 1'b0;
  logic       ready1, tx1, busy1, done1;
  logic       ready2, tx2, busy2, done2;

  tick_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(valid1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1));

  tick_serializer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .data(data), .valid(valid2),
    .ready(ready2), .tx(tx2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_per = 4;
  int tick_cnt = 0;
  bit use_src = 1'b1;
  int src_sel = 0;
  bit cmp_en = 1'b0;
  logic [7:0] src_q[$];

  // Line model: each accepted word becomes a list of line bits; a position pointer
  // advances on every tick after acceptance (-1 means still waiting for the first tick).
  bit          m_act[2];
  int          m_pos[2];
  logic [15:0] m_frm[2];
  bit          m_done[2];
  int          m_nb[2] = '{10, 11};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int m, input logic v);
    m_done[m] = 1'b0;
    if (rst) begin
      m_act[m] = 1'b0;
    end else if (!m_act[m]) begin
      if (v) begin
        m_act[m] = 1'b1;
        m_pos[m] = -1;
        m_frm[m] = '1;
        m_frm[m][0] = 1'b0;
        m_frm[m][8:1] = data;
      end
    end else if (tick) begin
      m_pos[m]++;
      if (m_pos[m] == m_nb[m]) begin
        m_act[m] = 1'b0;
        m_done[m] = 1'b1;
      end
    end
  endtask

  function automatic logic m_tx(input int m);
    if (m_act[m] && m_pos[m] >= 0) return m_frm[m][m_pos[m]];
    return 1'b1;
  endfunction

  function automatic logic tx_of(input int w);   return (w == 0) ? tx1 : tx2;       endfunction
  function automatic logic done_of(input int w); return (w == 0) ? done1 : done2;   endfunction
  function automatic logic rdy_of(input int w);  return (w == 0) ? ready1 : ready2; endfunction
  function automatic logic busy_of(input int w); return (w == 0) ? busy1 : busy2;   endfunction

  task automatic cycle();
    logic acc;
    if (use_src) begin
      valid1 = (src_sel == 0) && (src_q.size() != 0);
      valid2 = (src_sel == 1) && (src_q.size() != 0);
      if (src_q.size() != 0) data = src_q[0];
    end
    tick = (tick_per > 0) && (tick_cnt == tick_per - 1);
    acc = (valid1 && ready1) || (valid2 && ready2);
    @(posedge clk);
    model_step(0, valid1);
    model_step(1, valid2);
    #1;
    cyc++;
    if (use_src && acc && !rst && src_q.size() != 0) void'(src_q.pop_front());
    if (use_src && src_q.size() == 0) begin
      valid1 = 1'b0;
      valid2 = 1'b0;
    end
    if (tick_per > 0) tick_cnt = (tick_cnt + 1) % tick_per;
    if (cmp_en) begin
      chk("m1_tx", tx1, m_tx(0));     chk("m1_ready", ready1, !m_act[0]);
      chk("m1_busy", busy1, m_act[0]); chk("m1_done", done1, m_done[0]);
      chk("m2_tx", tx2, m_tx(1));     chk("m2_ready", ready2, !m_act[1]);
      chk("m2_busy", busy2, m_act[1]); chk("m2_done", done2, m_done[1]);
    end
  endtask

  // Waits for the start bit, then checks each line bit holds for tick_per samples,
  // followed by the sample that must carry done with the block idle.
  task automatic check_frame(input string name, input int w, input logic [31:0] pat,
                             input int nbits, input int exp_done, input int exp_busy,
                             output int waited);
    int nd = 0;
    int nb = 0;
    waited = 0;
    while (tx_of(w) !== 1'b0 && waited < 10 * tick_per + 10) begin
      cycle();
      waited++;
      if (tx_of(w) !== 1'b0 && busy_of(w)) nb++;
    end
    chk({name, "_start"}, tx_of(w), 1'b0);
    for (int i = 0; i < nbits; i++) begin
      for (int k = 0; k < tick_per; k++) begin
        if (i != 0 || k != 0) cycle();
        chk($sformatf("%s_bit%0d", name, i), tx_of(w), pat[i]);
        if (done_of(w)) nd++;
        if (busy_of(w)) nb++;
      end
    end
    cycle();
    if (done_of(w)) nd++;
    chk({name, "_done_end"}, done_of(w), 1'b1);
    chk({name, "_ready_end"}, rdy_of(w), 1'b1);
    chk({name, "_busy_end"}, busy_of(w), 1'b0);
    chk({name, "_done_cnt"}, nd, exp_done);
    if (exp_busy > 0) chk({name, "_busy_cycles"}, nb, exp_busy);
  endtask

  typedef struct {
    int         per;
    logic [7:0] d;
    logic [31:0] pat;
    int         busy_cyc;
  } vec_t;

  vec_t vt[5];

  initial begin
    #900000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int waited;
    // Line patterns listed bit 0 first: start, 8 data bits LSB first, stop.
    vt[0] = '{per: 4, d: 8'hA5, pat: 32'h34A, busy_cyc: 0};
    vt[1] = '{per: 1, d: 8'h3C, pat: 32'h278, busy_cyc: 11};
    vt[2] = '{per: 3, d: 8'h00, pat: 32'h200, busy_cyc: 0};
    vt[3] = '{per: 2, d: 8'hFF, pat: 32'h3FE, busy_cyc: 0};
    vt[4] = '{per: 1, d: 8'h81, pat: 32'h302, busy_cyc: 11};

    // Reset state
    rst = 1'b1;
    repeat (2) cycle();
    chk("rst_tx1", tx1, 1'b1);   chk("rst_ready1", ready1, 1'b1);
    chk("rst_busy1", busy1, 1'b0); chk("rst_done1", done1, 1'b0);
    chk("rst_tx2", tx2, 1'b1);   chk("rst_ready2", ready2, 1'b1);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Ticks with nothing offered
    tick_per = 2; tick_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("idle_tx", tx1, 1'b1);
      chk("idle_done", done1, 1'b0);
      chk("idle_busy", busy1, 1'b0);
    end

    // Single frames at several tick rates
    for (int v = 0; v < 5; v++) begin
      tick_per = vt[v].per; tick_cnt = 0;
      src_q.push_back(vt[v].d);
      check_frame($sformatf("vec%0d", v), 0, vt[v].pat, 10, 1, vt[v].busy_cyc, waited);
      repeat (3) cycle();
    end

    // Back-to-back 0x00 then 0xFF with valid held: stop bit, then one SYNC period high
    tick_per = 4; tick_cnt = 0;
    src_q.push_back(8'h00);
    src_q.push_back(8'hFF);
    check_frame("b2b", 0, 32'h1FF600, 21, 2, 0, waited);
    repeat (3) cycle();

    // Reset in data bit 3 of 0x55 aborts the frame, then 0x81 goes out cleanly
    tick_per = 4; tick_cnt = 0;
    src_q.push_back(8'h55);
    waited = 0;
    while (tx1 !== 1'b0 && waited < 50) begin cycle(); waited++; end
    repeat (17) cycle();
    chk("pre_rst_bit3", tx1, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("abort_tx", tx1, 1'b1);   chk("abort_ready", ready1, 1'b1);
    chk("abort_busy", busy1, 1'b0); chk("abort_done", done1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("abort_no_done", done1, 1'b0);
    end
    src_q.push_back(8'h81);
    check_frame("after_abort", 0, 32'h302, 10, 1, 0, waited);
    repeat (3) cycle();

    // Two stop bits
    src_sel = 1;
    tick_per = 4; tick_cnt = 0;
    src_q.push_back(8'h01);
    check_frame("stop2", 1, 32'h602, 11, 1, 0, waited);
    repeat (3) cycle();
    src_sel = 0;

    // Acceptance in the same cycle as a tick: that tick does not start the frame
    tick_per = 4; tick_cnt = 0;
    waited = 0;
    while (tick_cnt != tick_per - 1 && waited < 10) begin cycle(); waited++; end
    src_q.push_back(8'hA5);
    cycle();
    chk("same_tick_tx", tx1, 1'b1);
    chk("same_tick_busy", busy1, 1'b1);
    check_frame("same_tick", 0, 32'h34A, 10, 1, 0, waited);
    chk("same_tick_wait", waited, 4);
    repeat (3) cycle();

    // Randomized traffic against the model, including tick gaps and resets
    use_src = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        tick_per = int'($urandom_range(0, 5));
        tick_cnt = 0;
      end
      valid1 = ($urandom_range(0, 3) == 0);
      valid2 = ($urandom_range(0, 3) == 0);
      data = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
